// File: rtl/cg_memory_arbiter.sv
// Two-master arbiter in front of one memory with independent read and write channels.
// Latency: read accept to m_rvalid is 2 cycles; writes pass through combinationally (0 cycles).
// Backpressure: m_rready low holds the 1-entry response buffer, and that master is not granted until it drains.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   m_ar{valid,ready,addr}           per-master read request channel (bit/slice i = master i)
//   m_r{valid,ready,data}            per-master buffered read response
//   m_w{valid,ready,addr,data}       per-master write channel
//   mem_ar*, mem_r*, mem_w*, mem_wen memory-side channels (fixed 1-cycle read latency, rdata not held)
//   err                              sticky protocol error (rvalid without an outstanding read, or vice versa)
module cg_memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              m_arvalid,
    output logic [1:0]              m_arready,
    input  logic [2*ADDR_WIDTH-1:0] m_araddr,
    output logic [1:0]              m_rvalid,
    input  logic [1:0]              m_rready,
    output logic [2*DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]              m_wvalid,
    output logic [1:0]              m_wready,
    input  logic [2*ADDR_WIDTH-1:0] m_waddr,
    input  logic [2*DATA_WIDTH-1:0] m_wdata,
    output logic                    mem_arvalid,
    input  logic                    mem_arready,
    output logic [ADDR_WIDTH-1:0]   mem_araddr,
    input  logic                    mem_rvalid,
    output logic                    mem_rready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_wen,
    output logic                    mem_wvalid,
    input  logic                    mem_wready,
    output logic [ADDR_WIDTH-1:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    err
);

    logic [1:0]            buf_valid;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  infl_valid;
    logic                  infl_id;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  rst_q;       // high for the first cycle after reset releases

    logic [1:0]            rd_elig;
    logic                  rd_gnt;
    logic                  rd_fire;
    logic [1:0]            rd_hs;
    logic                  wr_gnt;
    logic                  wr_fire;

    // A master is skipped while its buffer is full or its previous read is
    // still in flight, so a stalled master never blocks the other one.
    always_comb begin
        rd_elig[0] = m_arvalid[0] & ~buf_valid[0] & ~(infl_valid & (infl_id == 1'b0));
        rd_elig[1] = m_arvalid[1] & ~buf_valid[1] & ~(infl_valid & (infl_id == 1'b1));
    end

    assign rd_gnt  = (&rd_elig) ? rd_ptr : rd_elig[1];
    // The memory registers arvalid without looking at its own ready, so only
    // an accepted request may be presented.
    assign rd_fire = (|rd_elig) & mem_arready & ~rst;

    assign mem_arvalid = rd_fire;
    assign m_arready   = rd_fire ? (rd_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign mem_araddr  = rd_gnt ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_araddr[ADDR_WIDTH-1:0];
    assign mem_rready  = ~rst;

    assign m_rvalid = buf_valid & {2{~rst}};
    assign m_rdata  = {buf_data[1], buf_data[0]};
    assign rd_hs    = m_rvalid & m_rready;

    assign wr_gnt     = (&m_wvalid) ? wr_ptr : m_wvalid[1];
    assign mem_wvalid = (|m_wvalid) & ~rst;
    assign mem_wen    = mem_wvalid;
    assign wr_fire    = mem_wvalid & mem_wready;
    assign mem_waddr  = wr_gnt ? m_waddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_waddr[ADDR_WIDTH-1:0];
    assign mem_wdata  = wr_gnt ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];

    always_comb begin
        m_wready = 2'b00;
        if (!rst) begin
            m_wready = wr_gnt ? {mem_wready, 1'b0} : {1'b0, mem_wready};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid   <= 2'b00;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            infl_valid  <= 1'b0;
            infl_id     <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            err         <= 1'b0;
            rst_q       <= 1'b1;
        end else begin
            rst_q      <= 1'b0;
            infl_valid <= rd_fire;
            if (rd_fire) begin
                infl_id <= rd_gnt;
                rd_ptr  <= ~rd_gnt;
            end
            if (wr_fire) begin
                wr_ptr <= ~wr_gnt;
            end
            for (int i = 0; i < 2; i++) begin
                if (rd_hs[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            // The in-flight master's buffer is empty by construction, so the
            // capture never collides with a drain of the same entry.
            if (infl_valid) begin
                buf_valid[infl_id] <= 1'b1;
                buf_data[infl_id]  <= mem_rdata;
            end
            // A response that belonged to a read discarded by reset may still
            // arrive in the first cycle afterwards; ignore it.
            if (!rst_q && (mem_rvalid != infl_valid)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cg_memory_arbiter.sv
module tb_cg_memory_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  m_arvalid;
    logic [1:0]  m_arready;
    logic [63:0] m_araddr;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_rready;
    logic [63:0] m_rdata;
    logic [1:0]  m_wvalid;
    logic [1:0]  m_wready;
    logic [63:0] m_waddr;
    logic [63:0] m_wdata;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    cg_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: 16 words, registered 1-cycle read, read-before-write.
    logic [31:0] mem [16];
    logic        init_mem;
    logic        rv_q;
    logic        rv_inj;

    always @(posedge clk) begin
        rv_q <= mem_arvalid;
        if (mem_arvalid) mem_rdata <= mem[mem_araddr[3:0]];
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[5] <= 32'hDEADBEEF;
            mem[7] <= 32'h0000000A;
        end else if (mem_wen) begin
            mem[mem_waddr[3:0]] <= mem_wdata;
        end
    end

    assign mem_rvalid = rv_q | rv_inj;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] t2_ar [6];
    logic [1:0] t2_rv [6];
    logic [1:0] t3_ar [9];
    int m0_acc;
    int m1_acc;

    initial begin
        t2_ar = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
        t2_rv = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        t3_ar = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00};

        rst = 1'b1; init_mem = 1'b1; rv_inj = 1'b0;
        mem_arready = 1'b1; mem_wready = 1'b1;
        m_arvalid = 2'b11; m_araddr = '0; m_rready = 2'b00;
        m_wvalid = 2'b11; m_waddr = '0; m_wdata = '0;
        tick; tick;
        chk("rst_arready", m_arready, 2'b00);
        chk("rst_mem_arvalid", mem_arvalid, 1'b0);
        chk("rst_wready", m_wready, 2'b00);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_mem_wvalid", mem_wvalid, 1'b0);
        chk("rst_mem_rready", mem_rready, 1'b0);
        init_mem = 1'b0; rst = 1'b0; m_arvalid = 2'b00; m_wvalid = 2'b00;
        #1;
        chk("idle_rvalid", m_rvalid, 2'b00);
        chk("idle_rdata", m_rdata, 64'h0);
        chk("idle_err", err, 1'b0);
        chk("idle_mem_rready", mem_rready, 1'b1);

        // Single read of mem[5] by M0, response held while rready is low.
        tick; m_arvalid = 2'b01; m_araddr = {32'd7, 32'd5}; #1;
        chk("t1_arready", m_arready, 2'b01);
        chk("t1_mem_arvalid", mem_arvalid, 1'b1);
        chk("t1_mem_araddr", mem_araddr, 32'd5);
        tick; m_arvalid = 2'b00; #1;
        chk("t1_rvalid_c1", m_rvalid, 2'b00);
        tick; #1;
        chk("t1_rvalid_c2", m_rvalid, 2'b01);
        chk("t1_rdata_c2", m_rdata[31:0], 32'hDEADBEEF);
        tick; #1;
        chk("t1_rvalid_c3", m_rvalid, 2'b01);
        tick; m_rready = 2'b01; #1;
        chk("t1_rvalid_c4", m_rvalid, 2'b01);
        chk("t1_rdata_c4", m_rdata[31:0], 32'hDEADBEEF);
        tick; #1;
        chk("t1_rvalid_c5", m_rvalid, 2'b00);
        chk("t1_err", err, 1'b0);

        // Reset so the read pointer starts at M0, then both masters stream.
        tick; rst = 1'b1; m_rready = 2'b11;
        tick; rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick; m_arvalid = 2'b11; #1;
            chk($sformatf("t2_arready_%0d", k), m_arready, t2_ar[k]);
            chk($sformatf("t2_rvalid_%0d", k), m_rvalid, t2_rv[k]);
            if (k == 2) chk("t2_rdata_m0", m_rdata[31:0], 32'hDEADBEEF);
            if (k == 3) chk("t2_rdata_m1", m_rdata[63:32], 32'h0000000A);
        end
        tick; m_arvalid = 2'b00; #1;
        chk("t2_rvalid_6", m_rvalid, 2'b10);
        chk("t2_rdata_m1_b", m_rdata[63:32], 32'h0000000A);
        tick; #1;
        chk("t2_rvalid_7", m_rvalid, 2'b00);

        // M0 stalls its response; M1 keeps being served.
        m0_acc = 0; m1_acc = 0;
        for (int k = 0; k < 9; k++) begin
            tick; m_arvalid = 2'b11; m_rready = 2'b10; #1;
            chk($sformatf("t3_arready_%0d", k), m_arready, t3_ar[k]);
            if (m_arready[0]) m0_acc++;
            if (m_arready[1]) m1_acc++;
        end
        chk("t3_m0_accepts", m0_acc, 1);
        chk("t3_m1_accepts", m1_acc, 3);
        chk("t3_m0_rvalid", m_rvalid[0], 1'b1);
        chk("t3_m0_rdata", m_rdata[31:0], 32'hDEADBEEF);
        tick; m_arvalid = 2'b00; m_rready = 2'b11;
        tick; #1;
        chk("t3_drained", m_rvalid, 2'b00);

        // Simultaneous writes to address 3: M0 first, then M1.
        tick; m_wvalid = 2'b11; m_waddr = {32'd3, 32'd3}; m_wdata = {32'h22, 32'h11}; #1;
        chk("t4_wready_c0", m_wready, 2'b01);
        chk("t4_mem_wen_c0", mem_wen, 1'b1);
        chk("t4_mem_waddr_c0", mem_waddr, 32'd3);
        chk("t4_mem_wdata_c0", mem_wdata, 32'h11);
        tick; m_wvalid = 2'b10; #1;
        chk("t4_wready_c1", m_wready, 2'b10);
        chk("t4_mem_wdata_c1", mem_wdata, 32'h22);
        tick; m_wvalid = 2'b00; m_arvalid = 2'b01; m_araddr = {32'd0, 32'd3}; #1;
        chk("t4_mem_wvalid_idle", mem_wvalid, 1'b0);
        chk("t4_rd_arready", m_arready, 2'b01);
        tick; m_arvalid = 2'b00;
        tick; #1;
        chk("t4_rd_rvalid", m_rvalid, 2'b01);
        chk("t4_rd_rdata", m_rdata[31:0], 32'h22);

        // Same-cycle read (M0) and write (M1) of address 7.
        tick; m_arvalid = 2'b01; m_araddr = {32'd0, 32'd7};
        m_wvalid = 2'b10; m_waddr = {32'd7, 32'd0}; m_wdata = {32'hB, 32'h0}; #1;
        chk("t5_wready", m_wready, 2'b10);
        chk("t5_arready", m_arready, 2'b01);
        tick; m_arvalid = 2'b00; m_wvalid = 2'b00;
        tick; #1;
        chk("t5_rvalid_old", m_rvalid, 2'b01);
        chk("t5_rdata_old", m_rdata[31:0], 32'h0000000A);
        tick; m_arvalid = 2'b01; #1;
        chk("t5_arready_new", m_arready, 2'b01);
        tick; m_arvalid = 2'b00;
        tick; #1;
        chk("t5_rdata_new", m_rdata[31:0], 32'h0000000B);

        // Memory not ready: nothing is accepted.
        tick; mem_arready = 1'b0; m_arvalid = 2'b11; #1;
        chk("t6_noready_arready", m_arready, 2'b00);
        chk("t6_noready_mem_arvalid", mem_arvalid, 1'b0);
        mem_arready = 1'b1; m_arvalid = 2'b00;

        // Reset one cycle after a read accept, with a stray late response.
        tick; m_arvalid = 2'b01; m_araddr = {32'd0, 32'd5}; #1;
        chk("t7_arready", m_arready, 2'b01);
        tick; rst = 1'b1; #1;
        chk("t7_rst_arready", m_arready, 2'b00);
        chk("t7_rst_rvalid", m_rvalid, 2'b00);
        tick; rst = 1'b0; m_arvalid = 2'b00; rv_inj = 1'b1; #1;
        chk("t7_post_rvalid", m_rvalid, 2'b00);
        tick; rv_inj = 1'b0; #1;
        chk("t7_post_err", err, 1'b0);
        chk("t7_post_rvalid2", m_rvalid, 2'b00);
        tick; m_arvalid = 2'b01; #1;
        chk("t7_new_arready", m_arready, 2'b01);
        tick; m_arvalid = 2'b00; #1;
        chk("t7_new_rvalid_c1", m_rvalid, 2'b00);
        tick; #1;
        chk("t7_new_rvalid_c2", m_rvalid, 2'b01);
        chk("t7_new_rdata", m_rdata[31:0], 32'hDEADBEEF);

        // Spurious memory response sets the sticky error.
        tick; rv_inj = 1'b1; #1;
        chk("t8_err_before", err, 1'b0);
        tick; rv_inj = 1'b0; #1;
        chk("t8_err_set", err, 1'b1);
        tick; #1;
        chk("t8_err_sticky", err, 1'b1);
        tick; rst = 1'b1;
        tick; rst = 1'b0; #1;
        chk("t8_err_cleared", err, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
